// File: rtl/inta_sequencer_if.sv
// Signal bundle between the priority resolver / CPU side and the INTA sequencer.
interface inta_sequencer_if;
    logic       INTA_n;
    logic       INT_req;
    logic [2:0] IRQ_sel;
    logic [2:0] ISR_Control;
    logic       ISR_any;
    logic [4:0] ICW2_base;
    logic       AEOI;
    logic       ocw2_wr;
    logic [7:0] ocw2;
    logic       INT;
    logic [7:0] ISR;
    logic       ISR_DONE_vld;
    logic [2:0] ISR_DONE;
    logic [2:0] n;
    logic [2:0] rotate;
    logic [7:0] data_out;
    logic       data_oe;

    modport master (
        output INTA_n, INT_req, IRQ_sel, ISR_Control, ISR_any, ICW2_base, AEOI, ocw2_wr, ocw2,
        input  INT, ISR, ISR_DONE_vld, ISR_DONE, n, rotate, data_out, data_oe
    );

    modport slave (
        input  INTA_n, INT_req, IRQ_sel, ISR_Control, ISR_any, ICW2_base, AEOI, ocw2_wr, ocw2,
        output INT, ISR, ISR_DONE_vld, ISR_DONE, n, rotate, data_out, data_oe
    );
endinterface

// File: rtl/inta_sequencer.sv
// Interrupt-acknowledge sequencer: two-pulse INTA handshake, vector drive, EOI/AEOI clears.
// Optional priority rotation is enabled by defining INTA_ROTATE_EN.
module inta_sequencer (
    input  logic            clk,
    input  logic            reset,
    inta_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PEND = 3'd1,
        ACK1 = 3'd2,
        GAP  = 3'd3,
        ACK2 = 3'd4
    } state_t;

    state_t     state_r, state_nxt_s;
    logic       inta_q_r;
    logic       inta_fall_s, inta_rise_s;
    logic [2:0] lvl_r, lvl_nxt_s;
    logic       spur_r, spur_nxt_s;
    logic       isr_set_s, aeoi_clr_s;

    logic       ocw_clr_s, ocw_rot_s, ocw_setn_s, ocw_aeoi_on_s, ocw_aeoi_off_s;
    logic [2:0] ocw_lvl_s;
    logic       rot_aeoi_r;

    logic       pend_vld_r, pend_rot_r, pend_vld_nxt_s, pend_rot_nxt_s;
    logic [2:0] pend_lvl_r, pend_lvl_nxt_s;
    logic       done_vld_s, done_rot_s;
    logic [2:0] done_lvl_s;

    logic       int_r, done_vld_r, data_oe_r;
    logic [7:0] isr_r, data_out_r;
    logic [2:0] done_r, n_r, rotate_r;

    assign inta_fall_s = inta_q_r & ~bus.INTA_n;
    assign inta_rise_s = ~inta_q_r & bus.INTA_n;

    // Acknowledge FSM next-state, level latch and ISR-set / AEOI-clear requests
    always_comb begin
        state_nxt_s = state_r;
        lvl_nxt_s   = lvl_r;
        spur_nxt_s  = spur_r;
        isr_set_s   = 1'b0;
        aeoi_clr_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.INT_req) state_nxt_s = PEND;
                else             state_nxt_s = IDLE;
            end
            PEND: begin
                if (inta_fall_s) begin
                    state_nxt_s = ACK1;
                    if (bus.INT_req) begin
                        lvl_nxt_s  = bus.IRQ_sel;
                        spur_nxt_s = 1'b0;
                        isr_set_s  = 1'b1;
                    end else begin
                        lvl_nxt_s  = 3'd7;
                        spur_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = PEND;
                end
            end
            ACK1: begin
                if (inta_rise_s) state_nxt_s = GAP;
                else             state_nxt_s = ACK1;
            end
            GAP: begin
                if (inta_fall_s) state_nxt_s = ACK2;
                else             state_nxt_s = GAP;
            end
            ACK2: begin
                if (inta_rise_s) begin
                    state_nxt_s = IDLE;
                    aeoi_clr_s  = bus.AEOI & ~spur_r;
                end else begin
                    state_nxt_s = ACK2;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // OCW2 command decode; rotating forms fold to plain EOI without rotation support
    always_comb begin
        ocw_clr_s      = 1'b0;
        ocw_rot_s      = 1'b0;
        ocw_setn_s     = 1'b0;
        ocw_aeoi_on_s  = 1'b0;
        ocw_aeoi_off_s = 1'b0;
        ocw_lvl_s      = 3'd0;
        if (bus.ocw2_wr) begin
            case (bus.ocw2[7:5])
                3'b001: begin ocw_clr_s = bus.ISR_any; ocw_lvl_s = bus.ISR_Control; end
                3'b011: begin ocw_clr_s = 1'b1;        ocw_lvl_s = bus.ocw2[2:0];   end
`ifdef INTA_ROTATE_EN
                3'b101: begin ocw_clr_s = bus.ISR_any; ocw_lvl_s = bus.ISR_Control; ocw_rot_s = 1'b1; end
                3'b111: begin ocw_clr_s = 1'b1;        ocw_lvl_s = bus.ocw2[2:0];   ocw_rot_s = 1'b1; end
                3'b110: ocw_setn_s     = 1'b1;
                3'b100: ocw_aeoi_on_s  = 1'b1;
                3'b000: ocw_aeoi_off_s = 1'b1;
`else
                3'b101: begin ocw_clr_s = bus.ISR_any; ocw_lvl_s = bus.ISR_Control; end
                3'b111: begin ocw_clr_s = 1'b1;        ocw_lvl_s = bus.ocw2[2:0];   end
`endif
                default: ocw_clr_s = 1'b0;
            endcase
        end else begin
            ocw_clr_s = 1'b0;
        end
    end

    // Clear arbitration: AEOI first; OCW clears defer while AEOI or an ISR set owns the cycle
    always_comb begin
        done_vld_s     = 1'b0;
        done_lvl_s     = 3'd0;
        done_rot_s     = 1'b0;
        pend_vld_nxt_s = pend_vld_r;
        pend_lvl_nxt_s = pend_lvl_r;
        pend_rot_nxt_s = pend_rot_r;
        if (aeoi_clr_s || isr_set_s) begin
            if (aeoi_clr_s) begin
                done_vld_s = 1'b1;
                done_lvl_s = lvl_r;
                done_rot_s = rot_aeoi_r;
            end else begin
                done_vld_s = 1'b0;
            end
            if (ocw_clr_s) begin
                pend_vld_nxt_s = 1'b1;
                pend_lvl_nxt_s = ocw_lvl_s;
                pend_rot_nxt_s = ocw_rot_s;
            end else begin
                pend_vld_nxt_s = pend_vld_r;
            end
        end else if (ocw_clr_s) begin
            done_vld_s     = 1'b1;
            done_lvl_s     = ocw_lvl_s;
            done_rot_s     = ocw_rot_s;
            pend_vld_nxt_s = 1'b0;
        end else if (pend_vld_r) begin
            done_vld_s     = 1'b1;
            done_lvl_s     = pend_lvl_r;
            done_rot_s     = pend_rot_r;
            pend_vld_nxt_s = 1'b0;
        end else begin
            pend_vld_nxt_s = 1'b0;
        end
    end

    // State, pending entry and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            inta_q_r   <= 1'b1;
            lvl_r      <= 3'd0;
            spur_r     <= 1'b0;
            rot_aeoi_r <= 1'b0;
            pend_vld_r <= 1'b0;
            pend_lvl_r <= 3'd0;
            pend_rot_r <= 1'b0;
            int_r      <= 1'b0;
            isr_r      <= 8'd0;
            done_vld_r <= 1'b0;
            done_r     <= 3'd0;
            n_r        <= 3'd0;
            rotate_r   <= 3'd0;
            data_out_r <= 8'd0;
            data_oe_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            inta_q_r   <= bus.INTA_n;
            lvl_r      <= lvl_nxt_s;
            spur_r     <= spur_nxt_s;
            pend_vld_r <= pend_vld_nxt_s;
            pend_lvl_r <= pend_lvl_nxt_s;
            pend_rot_r <= pend_rot_nxt_s;
            int_r      <= (state_nxt_s == PEND);
            isr_r      <= isr_set_s ? (8'd1 << lvl_nxt_s) : 8'd0;
            done_vld_r <= done_vld_s;
            done_r     <= done_vld_s ? done_lvl_s : 3'd0;
            data_oe_r  <= (state_nxt_s == ACK2);
            data_out_r <= (state_nxt_s == ACK2) ? {bus.ICW2_base, lvl_nxt_s} : 8'd0;
            // An explicit set-priority command outranks rotation implied by a clear
            if (ocw_setn_s)                    n_r <= bus.ocw2[2:0] + 3'd1;
            else if (done_vld_s && done_rot_s) n_r <= done_lvl_s + 3'd1;
            if (bus.ocw2_wr) rotate_r <= bus.ocw2[7:5];
            if (ocw_aeoi_on_s)       rot_aeoi_r <= 1'b1;
            else if (ocw_aeoi_off_s) rot_aeoi_r <= 1'b0;
        end
    end

    assign bus.INT          = int_r;
    assign bus.ISR          = isr_r;
    assign bus.ISR_DONE_vld = done_vld_r;
    assign bus.ISR_DONE     = done_r;
    assign bus.n            = n_r;
    assign bus.rotate       = rotate_r;
    assign bus.data_out     = data_out_r;
    assign bus.data_oe      = data_oe_r;
endmodule

// File: tb/tb_inta_sequencer.sv
// Self-checking bench for inta_sequencer: acknowledge sequences, OCW2 vector table, reset abort.
module tb_inta_sequencer;
    logic clk = 1'b0;
    logic reset;
    inta_sequencer_if bus ();

    inta_sequencer dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

`ifdef INTA_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] ocw;
        logic       any;
        logic [2:0] ctrl;
        logic       vld;
        logic [2:0] lvl;
        logic [2:0] n;
        logic [2:0] rot;
    } ocw_vec_t;

    typedef struct {
        logic       vld;
        logic [2:0] lvl;
        logic [2:0] n;
        logic [2:0] rot;
    } exp_t;

    ocw_vec_t tbl [11];
    exp_t     sb_q [$];

    function automatic logic [2:0] rn(input logic [2:0] v);
        return ROT ? v : 3'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_ocw(input int idx);
        exp_t e;
        bus.ocw2_wr     = 1'b1;
        bus.ocw2        = tbl[idx].ocw;
        bus.ISR_any     = tbl[idx].any;
        bus.ISR_Control = tbl[idx].ctrl;
        sb_q.push_back('{tbl[idx].vld, tbl[idx].lvl, tbl[idx].n, tbl[idx].rot});
        tick();
        bus.ocw2_wr = 1'b0;
        e = sb_q.pop_front();
        check($sformatf("ocw%0d_vld", idx), {31'd0, bus.ISR_DONE_vld}, {31'd0, e.vld});
        if (e.vld) check($sformatf("ocw%0d_lvl", idx), {29'd0, bus.ISR_DONE}, {29'd0, e.lvl});
        check($sformatf("ocw%0d_n", idx), {29'd0, bus.n}, {29'd0, e.n});
        check($sformatf("ocw%0d_rot", idx), {29'd0, bus.rotate}, {29'd0, e.rot});
        tick();
        check($sformatf("ocw%0d_vld_end", idx), {31'd0, bus.ISR_DONE_vld}, 32'd0);
    endtask

    task automatic ack_cycle(input string tag, input logic keep_req, input logic [2:0] sel,
                             input logic aeoi, input logic [7:0] exp_isr, input logic [7:0] exp_data,
                             input logic exp_done, input logic [2:0] exp_lvl,
                             input logic ocw_at_end, input logic [7:0] ocw_val);
        bus.INT_req = 1'b1;
        bus.IRQ_sel = sel;
        bus.AEOI    = aeoi;
        tick();
        check({tag, "_int_pend"}, {31'd0, bus.INT}, 32'd1);
        bus.INT_req = keep_req;
        tick();
        check({tag, "_int_hold"}, {31'd0, bus.INT}, 32'd1);
        bus.INTA_n = 1'b0;
        tick();
        bus.INT_req = 1'b0;
        check({tag, "_isr"}, {24'd0, bus.ISR}, {24'd0, exp_isr});
        check({tag, "_int_ack"}, {31'd0, bus.INT}, 32'd0);
        tick();
        check({tag, "_isr_end"}, {24'd0, bus.ISR}, 32'd0);
        bus.INTA_n = 1'b1;
        tick();
        check({tag, "_oe_gap"}, {31'd0, bus.data_oe}, 32'd0);
        bus.INTA_n = 1'b0;
        tick();
        check({tag, "_oe_ack2"}, {31'd0, bus.data_oe}, 32'd1);
        check({tag, "_data"}, {24'd0, bus.data_out}, {24'd0, exp_data});
        tick();
        bus.INTA_n = 1'b1;
        if (ocw_at_end) begin
            bus.ocw2_wr = 1'b1;
            bus.ocw2    = ocw_val;
        end
        tick();
        bus.ocw2_wr = 1'b0;
        check({tag, "_done_vld"}, {31'd0, bus.ISR_DONE_vld}, {31'd0, exp_done});
        if (exp_done) check({tag, "_done_lvl"}, {29'd0, bus.ISR_DONE}, {29'd0, exp_lvl});
        check({tag, "_oe_end"}, {31'd0, bus.data_oe}, 32'd0);
        check({tag, "_data_end"}, {24'd0, bus.data_out}, 32'd0);
        tick();
        check({tag, "_pend_vld"}, {31'd0, bus.ISR_DONE_vld}, {31'd0, ocw_at_end});
        if (ocw_at_end) check({tag, "_pend_lvl"}, {29'd0, bus.ISR_DONE}, {29'd0, ocw_val[2:0]});
        tick();
        check({tag, "_quiet"}, {31'd0, bus.ISR_DONE_vld}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{8'hA0, 1'b1, 3'd3, 1'b1, 3'd3, rn(3'd4), 3'd5};
        tbl[1]  = '{8'hA0, 1'b1, 3'd7, 1'b1, 3'd7, rn(3'd0), 3'd5};
        tbl[2]  = '{8'h20, 1'b1, 3'd5, 1'b1, 3'd5, rn(3'd0), 3'd1};
        tbl[3]  = '{8'h20, 1'b0, 3'd5, 1'b0, 3'd0, rn(3'd0), 3'd1};
        tbl[4]  = '{8'h63, 1'b0, 3'd0, 1'b1, 3'd3, rn(3'd0), 3'd3};
        tbl[5]  = '{8'hE6, 1'b0, 3'd0, 1'b1, 3'd6, rn(3'd7), 3'd7};
        tbl[6]  = '{8'hA0, 1'b0, 3'd2, 1'b0, 3'd0, rn(3'd7), 3'd5};
        tbl[7]  = '{8'hC1, 1'b0, 3'd0, 1'b0, 3'd0, rn(3'd2), 3'd6};
        tbl[8]  = '{8'h40, 1'b0, 3'd0, 1'b0, 3'd0, rn(3'd2), 3'd2};
        tbl[9]  = '{8'h80, 1'b0, 3'd0, 1'b0, 3'd0, rn(3'd2), 3'd4};
        tbl[10] = '{8'h00, 1'b0, 3'd0, 1'b0, 3'd0, rn(3'd5), 3'd0};

        reset           = 1'b1;
        bus.INTA_n      = 1'b1;
        bus.INT_req     = 1'b0;
        bus.IRQ_sel     = 3'd0;
        bus.ISR_Control = 3'd0;
        bus.ISR_any     = 1'b0;
        bus.ICW2_base   = 5'b01000;
        bus.AEOI        = 1'b0;
        bus.ocw2_wr     = 1'b0;
        bus.ocw2        = 8'h00;
        tick();
        tick();
        check("rst_int", {31'd0, bus.INT}, 32'd0);
        check("rst_isr", {24'd0, bus.ISR}, 32'd0);
        check("rst_done_vld", {31'd0, bus.ISR_DONE_vld}, 32'd0);
        check("rst_done", {29'd0, bus.ISR_DONE}, 32'd0);
        check("rst_n", {29'd0, bus.n}, 32'd0);
        check("rst_rotate", {29'd0, bus.rotate}, 32'd0);
        check("rst_data", {24'd0, bus.data_out}, 32'd0);
        check("rst_oe", {31'd0, bus.data_oe}, 32'd0);
        reset = 1'b0;
        tick();

        ack_cycle("basic", 1'b1, 3'd2, 1'b0, 8'h04, 8'h42, 1'b0, 3'd0, 1'b0, 8'h00);
        ack_cycle("aeoi", 1'b1, 3'd2, 1'b1, 8'h04, 8'h42, 1'b1, 3'd2, 1'b0, 8'h00);
        ack_cycle("spur", 1'b0, 3'd2, 1'b1, 8'h00, 8'h47, 1'b0, 3'd0, 1'b0, 8'h00);
        ack_cycle("lvl7", 1'b1, 3'd7, 1'b1, 8'h80, 8'h47, 1'b1, 3'd7, 1'b0, 8'h00);
        check("n_after_aeoi", {29'd0, bus.n}, 32'd0);

        for (int i = 0; i < 10; i++) apply_ocw(i);
        ack_cycle("rot_aeoi", 1'b1, 3'd4, 1'b1, 8'h10, 8'h44, 1'b1, 3'd4, 1'b0, 8'h00);
        check("n_rot_aeoi", {29'd0, bus.n}, {29'd0, rn(3'd5)});
        apply_ocw(10);
        ack_cycle("collide", 1'b1, 3'd1, 1'b1, 8'h02, 8'h41, 1'b1, 3'd1, 1'b1, 8'h63);
        check("n_collide", {29'd0, bus.n}, {29'd0, rn(3'd5)});
        check("rotate_collide", {29'd0, bus.rotate}, 32'd3);

        bus.AEOI    = 1'b1;
        bus.INT_req = 1'b1;
        bus.IRQ_sel = 3'd6;
        tick();
        bus.INTA_n = 1'b0;
        tick();
        bus.INT_req = 1'b0;
        check("gap_isr", {24'd0, bus.ISR}, 32'h40);
        bus.INTA_n = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstgap_int", {31'd0, bus.INT}, 32'd0);
        check("rstgap_isr", {24'd0, bus.ISR}, 32'd0);
        check("rstgap_done", {31'd0, bus.ISR_DONE_vld}, 32'd0);
        check("rstgap_n", {29'd0, bus.n}, 32'd0);
        check("rstgap_rotate", {29'd0, bus.rotate}, 32'd0);
        check("rstgap_oe", {31'd0, bus.data_oe}, 32'd0);
        check("rstgap_data", {24'd0, bus.data_out}, 32'd0);
        bus.INTA_n = 1'b0;
        tick();
        tick();
        check("post_oe", {31'd0, bus.data_oe}, 32'd0);
        check("post_int", {31'd0, bus.INT}, 32'd0);
        bus.INTA_n = 1'b1;
        tick();
        check("post_done", {31'd0, bus.ISR_DONE_vld}, 32'd0);
        check("post_oe_end", {31'd0, bus.data_oe}, 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
